// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, flag bit positions
// and the arbiter FSM state type.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    MOD = 4'b0100,
    MUL = 4'b0101,
    DIV = 4'b0110,
    XOR = 4'b0111,
    SHL = 4'b1000,
    SHR = 4'b1001
  } alu_op_e;

  // Highest legal opcode; anything above is flagged as an error.
  localparam logic [3:0] ALU_OP_MAX = 4'b1001;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant.
// Ports:
//   req    - request vector, bit N for requester N
//   last   - id of the requester granted most recently
//   gnt    - one-hot grant (all zero when nothing is requested)
//   gnt_id - index of the granted requester (0 when nothing is granted)
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        // On a tie the requester that was not served last time wins.
        if (last) begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end else begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One operation is in flight
// at a time: accept (IDLE) -> hold operands for EXEC_CYCLES (EXEC) -> present
// the registered result until the consumer takes it (RESP).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b     - request channel of requester N (N = 0, 1)
//   rsp_valid/ready             - response handshake
//   rsp_id, rsp_result,
//   rsp_flags, rsp_err          - response payload
//   alu_a, alu_b, alu_sel       - operands/opcode to the external ALU
//   alu_out, alu_flags          - result/flags from the external ALU
//   busy                        - an operation is in flight
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             busy
);

  localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             rid_q, rid_d;

  logic [1:0] gnt;
  logic       gnt_id;

  rr_grant2 u_grant (
    .req    ({req1_valid, req0_valid}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    res_d      = res_q;
    flags_d    = flags_q;
    err_d      = err_q;
    rid_d      = rid_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        // A grant only exists for a valid requester, so any grant is an accept.
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        if (gnt != 2'b00) begin
          op_d    = gnt_id ? req1_op : req0_op;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          id_d    = gnt_id;
          cnt_d   = CntInit;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_out;
          flags_d = alu_flags;
          err_d   = (op_q > ALU_OP_MAX);
          rid_d   = id_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
    end
  end

  // Operands come straight from the registers so they stay stable through EXEC.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rid_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural 4-bit ALU.
// Two instances: EXEC_CYCLES=1 (main) and EXEC_CYCLES=4 (latency check).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // ---------------- main DUT (EXEC_CYCLES = 1) ----------------
  logic       req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [3:0] req0_op = 0, req0_a = 0, req0_b = 0;
  logic [3:0] req1_op = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [3:0] rsp_result, rsp_flags, alu_a, alu_b, alu_sel, alu_out, alu_flags;

  alu_arbiter #(.WIDTH(4), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
  );

  // ---------------- second DUT (EXEC_CYCLES = 4) ----------------
  logic       q0_valid = 0, q1_valid = 0, q_rsp_ready = 1;
  logic [3:0] q0_op = 0, q0_a = 0, q0_b = 0;
  logic [3:0] q1_op = 0, q1_a = 0, q1_b = 0;
  logic       q0_ready, q1_ready, q_rsp_valid, q_rsp_id, q_rsp_err, q_busy;
  logic [3:0] q_rsp_result, q_rsp_flags, q_alu_a, q_alu_b, q_alu_sel, q_alu_out, q_alu_flags;

  alu_arbiter #(.WIDTH(4), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_op(q0_op),
    .req0_a(q0_a), .req0_b(q0_b),
    .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_op(q1_op),
    .req1_a(q1_a), .req1_b(q1_b),
    .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id),
    .rsp_result(q_rsp_result), .rsp_flags(q_rsp_flags), .rsp_err(q_rsp_err),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_sel(q_alu_sel),
    .alu_out(q_alu_out), .alu_flags(q_alu_flags), .busy(q_busy)
  );

  // Behavioural ALU: returns {N,Z,C,V, result}.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (b == 4'd0) ? a : a % b;
      4'd5: r = 4'(a * b);
      4'd6: r = (b == 4'd0) ? 4'd0 : a / b;
      4'd7: r = a ^ b;
      4'd8: begin
        r = {a[2:0], 1'b0};
        c = a[3];
      end
      4'd9: begin
        r = {1'b0, a[3:1]};
        c = a[0];
      end
      default: r = a;
    endcase
    return {r[3], (r == 4'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_model(alu_sel, alu_a, alu_b);
  always_comb {q_alu_flags, q_alu_out} = alu_model(q_alu_sel, q_alu_a, q_alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic [3:0] op, a, b;
    logic [3:0] res, flags;
    logic       err;
    string      name;
  } vec_t;

  // One full transaction on the main DUT with rsp_ready held high.
  task automatic run_txn(input vec_t v);
    int k;
    @(negedge clk);
    if (v.id) begin
      req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    #1;
    chk({v.name, " ready"}, {req1_ready, req0_ready}, v.id ? 2 : 1);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({v.name, " latency"}, k, 1);
    chk({v.name, " id"}, rsp_id, v.id);
    chk({v.name, " result"}, rsp_result, v.res);
    chk({v.name, " flags"}, rsp_flags, v.flags);
    chk({v.name, " err"}, rsp_err, v.err);
    @(negedge clk);
    chk({v.name, " rsp drop"}, {rsp_valid, busy}, 0);
  endtask

  vec_t vecs[$];
  int   acc_cyc[4];
  logic acc_id[4];

  initial begin
    int n, cyc, k;
    vecs.push_back('{0, 4'h0, 4'd7,    4'd3,    4'b1010, 4'b1001, 0, "add"});
    vecs.push_back('{1, 4'h1, 4'd5,    4'd7,    4'b1110, 4'b1010, 0, "sub"});
    vecs.push_back('{0, 4'h2, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 0, "and"});
    vecs.push_back('{1, 4'h3, 4'b0101, 4'b0010, 4'b0111, 4'b0000, 0, "or"});
    vecs.push_back('{0, 4'h7, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 0, "xor"});
    vecs.push_back('{1, 4'h5, 4'd3,    4'd5,    4'b1111, 4'b1000, 0, "mul"});
    vecs.push_back('{0, 4'h8, 4'b1001, 4'd0,    4'b0010, 4'b0010, 0, "shl"});
    vecs.push_back('{1, 4'h9, 4'b0011, 4'd0,    4'b0001, 4'b0010, 0, "shr"});
    vecs.push_back('{0, 4'h6, 4'd9,    4'd2,    4'b0100, 4'b0000, 0, "div"});
    vecs.push_back('{1, 4'h4, 4'd9,    4'd4,    4'b0001, 4'b0000, 0, "mod"});
    vecs.push_back('{0, 4'hd, 4'b0101, 4'b0011, 4'b0101, 4'b0000, 1, "bad op d"});
    vecs.push_back('{1, 4'hf, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 1, "bad op f"});

    // Reset state
    @(negedge clk);
    chk("reset outs", {busy, rsp_valid, rsp_id, rsp_err, rsp_result, rsp_flags}, 0);
    chk("reset alu", {alu_a, alu_b, alu_sel, req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Tie fairness: both held valid; last served was req1 so req0 goes first.
    @(negedge clk);
    req0_valid = 1; req0_op = 4'h0; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1; req1_op = 4'h0; req1_a = 4'd2; req1_b = 4'd2;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("tie one-hot", {req1_ready, req0_ready} == 2'b11, 0);
        acc_cyc[n] = cyc;
        acc_id[n]  = req1_ready;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("tie accepts", n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) chk($sformatf("tie order %0d", i), acc_id[i], i % 2);
      if (i > 0 && i < n) chk($sformatf("tie spacing %0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
    end
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("tie drain", busy, 0);

    // Backpressure: response held while rsp_ready is low, req0 locked out.
    rsp_ready = 0;
    req1_valid = 1; req1_op = 4'h2; req1_a = 4'b1100; req1_b = 4'b1010;
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_op = 4'h0; req0_a = 4'd1; req0_b = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp hold %0d", i), {rsp_valid, rsp_id, rsp_result, rsp_flags[3:2], req0_ready},
          {1'b1, 1'b1, 4'b1000, 2'b10, 1'b0});
      @(negedge clk);
    end
    req0_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    chk("bp release", {rsp_valid, busy}, 0);

    // EXEC_CYCLES = 4 instance: operands stable through EXEC, latency 5.
    @(negedge clk);
    q0_valid = 1; q0_op = 4'h0; q0_a = 4'd6; q0_b = 4'd1;
    #1;
    chk("x4 ready", q0_ready, 1);
    @(negedge clk);
    q0_valid = 0;
    q0_a = 4'd0; q0_b = 4'd0; q0_op = 4'hf;
    k = 0;
    while (!q_rsp_valid && k < 20) begin
      chk($sformatf("x4 alu stable %0d", k), {q_alu_a, q_alu_b, q_alu_sel, q_busy},
          {4'd6, 4'd1, 4'h0, 1'b1});
      @(negedge clk);
      k++;
    end
    chk("x4 latency", k, 4);
    chk("x4 result", {q_rsp_result, q_rsp_flags, q_rsp_err}, {4'b0111, 4'b0000, 1'b0});

    // Reset mid-EXEC: make req0 the last grant, then drop an in-flight op.
    run_txn('{0, 4'h0, 4'd1, 4'd2, 4'b0011, 4'b0000, 0, "pre rst"});
    @(negedge clk);
    req0_valid = 1; req0_op = 4'h1; req0_a = 4'd4; req0_b = 4'd1;
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk("rst pre busy", busy, 1);
    rst = 1;
    #1;
    chk("rst immediate", {busy, rsp_valid, rsp_result, alu_a}, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst no rsp %0d", i), {rsp_valid, busy}, 0);
    end
    req0_valid = 1;
    req1_valid = 1;
    #1;
    chk("rst tie to req0", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("final drain", busy, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester controller that shares one ALU instance (WIDTH-bit, 4-bit sel, flags {N,Z,C,V}) between independent masters. It accepts operations over valid/ready handshakes and arbitrates round-robin. It drives the ALU operands and opcode from stable registers for EXEC_CYCLES cycles, then returns registered result and flags on a shared response channel tagged with the requester ID. The ALU is instantiated by the parent and connected through the alu_* ports.

Parameters:
WIDTH, 4, operand/result width; must match the attached ALU.
EXEC_CYCLES, 1, cycles operands are held before the result is captured; legal range 1..15.

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst  in  1  reset; asynchronous, active-high.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  4  requester 0 opcode (ALU sel encoding).
req0_a, req0_b  in  WIDTH  requester 0 operands.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer takes the response.
rsp_id  out  1  requester that owns the response.
rsp_result  out  WIDTH  captured alu_out.
rsp_flags  out  4  captured alu_flags {N,Z,C,V}.
rsp_err  out  1  opcode was outside 0000..1001.
alu_a, alu_b  out  WIDTH  ALU operands.
alu_sel  out  4  ALU opcode.
alu_out  in  WIDTH  ALU result.
alu_flags  in  4  ALU flags.
busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values:
  - All outputs 0.
  - Operand/op registers 0.
  - cnt 0.
  - last_grant = 1, so req0 wins the first tie.
- IDLE:
  - Winner selection:
    - Only one reqN_valid high: that requester wins.
    - Both high: the requester != last_grant wins.
  - reqN_ready = 1 combinationally for the winner only, and only in IDLE. Acceptance = valid & ready.
  - At the accepting edge:
    - Latch op, a and b into opnd registers.
    - Latch id.
    - cnt <= EXEC_CYCLES-1.
    - State -> EXEC.
- alu_a, alu_b and alu_sel are driven directly from the opnd registers in every state, so they are stable through EXEC.
- EXEC:
  - If cnt != 0, decrement it.
  - If cnt == 0: capture alu_out into rsp_result and alu_flags into rsp_flags, set rsp_err = (op > 4'b1001), set rsp_id = id, state -> RESP.
- RESP:
  - rsp_valid = 1. rsp_* values are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: last_grant <= id, state -> IDLE, rsp_valid deasserts the next cycle.
- Timing:
  - Latency from the accept edge to the first rsp_valid cycle = EXEC_CYCLES+1 cycles.
  - Minimum spacing between accepts = EXEC_CYCLES+2 cycles. No accept is possible in the same cycle as a response handshake.
- Requesters must hold op/a/b stable while valid & !ready. The block samples them only at acceptance.
- Invalid opcode:
  - The transaction still completes.
  - Result is whatever the ALU produces (pass-through of A).
  - rsp_err = 1.
- Reset mid-operation (any state): the transaction is dropped, no response is issued, and all registers return to their reset values immediately (asynchronous).
- A requester whose valid drops before acceptance is simply not granted. No stale grant is kept.

Decomposition:
- Shared package alu_pkg:
  - Opcode enum alu_op_e: ADD=0000, SUB=0001, AND=0010, OR=0011, MOD=0100, MUL=0101, DIV=0110, XOR=0111, SHL=1000, SHR=1001.
  - Constant ALU_OP_MAX = 4'b1001.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - State enum arb_state_e {IDLE, EXEC, RESP}.
- Sub-module rr_grant2: combinational 2-way round-robin grant.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot, gnt_id.

Test Plan:
1. Single add: WIDTH=4, EXEC_CYCLES=1, req0 op=0000, a=7, b=3 -> req0_ready high one cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=1010, rsp_flags N=1, Z=0, V=1, rsp_err=0.
2. Tie fairness: both valid, held continuously, rsp_ready=1 -> grant order 0,1,0,1. Each accept spaced 3 cycles apart.
3. Backpressure: req1 AND 1100 & 1010 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=1000 (flags N=1, Z=0) held stable; no req0_ready during that time even if req0_valid=1.
4. Invalid op: req0 op=1101, a=0101 -> rsp_result=0101, rsp_err=1, rsp_flags Z=0, N=0, C=0, V=0.
5. Latency parameter: EXEC_CYCLES=4 -> alu_a, alu_b, alu_sel stable for 4 cycles; rsp_valid 5 cycles after accept.
6. Reset in EXEC: assert rst mid-EXEC -> busy=0, rsp_valid=0 immediately; no response issued for the dropped op; next tie after reset is granted to req0.
